// File: rtl/cosim_logic_pkg.sv
// Shared definitions for the logic-op co-simulation proxy: op encoding, the
// native bitwise evaluation and a software stand-in for the external model.
package cosim_logic_pkg;

  localparam int COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } logicOp_e;

  function automatic logic [63:0] nativeEval(logicOp_e opSel, logic [63:0] lhs, logic [63:0] rhs);
    logic [63:0] r;
    case (opSel)
      OP_AND:  r = lhs & rhs;
      OP_OR:   r = lhs | rhs;
      OP_XOR:  r = lhs ^ rhs;
      default: r = ~(lhs & rhs);
    endcase
    return r;
  endfunction

  // Stand-in for the external model; it can be switched to answer AND
  // requests with lhs ^ rhs, emulating a faulty model.
  logic stubXorOnAnd = 1'b0;

  function automatic logic [63:0] stubLogicOp(logic [1:0] opSel, logic [63:0] lhs, logic [63:0] rhs);
    if (stubXorOnAnd && (opSel == 2'b00)) begin
      return lhs ^ rhs;
    end
    return nativeEval(logicOp_e'(opSel), lhs, rhs);
  endfunction

endpackage

// File: rtl/cosim_logic_stage.sv
// One pipeline stage of the proxy: valid, result data and mismatch bit, all
// frozen while hold_i is high.
module cosim_logic_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             mis_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             mis_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             mis_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mis_q   <= 1'b0;
    end else if (!hold_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
      mis_q   <= mis_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign mis_o   = mis_q;

endmodule

// File: rtl/cosim_logic_proxy.sv
// Logic-op co-simulation proxy: native bitwise result, optional model result
// with cross-check, carried through a LAT-deep pipeline that stalls as a whole.
module cosim_logic_proxy
  import cosim_logic_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LAT       = 2,
  parameter int USE_MODEL = 1,
  parameter int CHECK     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       y,
  output logic                   mismatch,
  output logic [COUNT_WIDTH-1:0] mismatch_count
);

  localparam bit CHECK_EN = (USE_MODEL != 0) && (CHECK != 0);

  logic                    stall;
  logic                    accept;
  logic                    fire;
  logic [WIDTH-1:0]        nativeVal;
  logic [WIDTH-1:0]        resultVal;
  logic                    resultMis;
  logic [LAT:0]            validChain;
  logic [LAT:0]            misChain;
  logic [LAT:0][WIDTH-1:0] dataChain;
  logic                    mismatch_q;
  logic                    mismatch_d;
  logic [COUNT_WIDTH-1:0]  mismatchCount_q;
  logic [COUNT_WIDTH-1:0]  mismatchCount_d;

  assign stall     = validChain[LAT] & ~out_ready;
  assign in_ready  = rst_n & ~stall;
  assign accept    = in_valid & in_ready;
  assign fire      = validChain[LAT] & out_ready;
  assign nativeVal = WIDTH'(nativeEval(logicOp_e'(op), 64'(a), 64'(b)));

  if (USE_MODEL != 0) begin : gModel
    logic [WIDTH-1:0] modelVal;
    logic [WIDTH-1:0] modelClean;

    // The model is only consulted for a transfer that is actually accepted.
    always_comb begin
      modelVal = '0;
      if (accept) begin
        modelVal = WIDTH'(stubLogicOp(op, 64'(a), 64'(b)));
      end
    end

    always_comb begin
      modelClean = '0;
      for (int i = 0; i < WIDTH; i++) begin
        modelClean[i] = (modelVal[i] === 1'b1);
      end
    end

    assign resultVal = modelClean;
    assign resultMis = (CHECK != 0) && (modelVal !== nativeVal);
  end else begin : gNative
    assign resultVal = nativeVal;
    assign resultMis = 1'b0;
  end

  assign validChain[0] = accept;
  assign dataChain[0]  = resultVal;
  assign misChain[0]   = resultMis;

  for (genvar s = 0; s < LAT; s++) begin : gStage
    cosim_logic_stage #(
      .WIDTH(WIDTH)
    ) uStage (
      .clk    (clk),
      .rst_n  (rst_n),
      .hold_i (stall),
      .valid_i(validChain[s]),
      .data_i (dataChain[s]),
      .mis_i  (misChain[s]),
      .valid_o(validChain[s+1]),
      .data_o (dataChain[s+1]),
      .mis_o  (misChain[s+1])
    );
  end

  // Mismatch status is booked when the result is handed over, not when accepted.
  always_comb begin
    mismatch_d      = mismatch_q;
    mismatchCount_d = mismatchCount_q;
    if (CHECK_EN && fire && misChain[LAT]) begin
      mismatch_d = 1'b1;
      if (mismatchCount_q != {COUNT_WIDTH{1'b1}}) begin
        mismatchCount_d = mismatchCount_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch_q      <= 1'b0;
      mismatchCount_q <= '0;
    end else begin
      mismatch_q      <= mismatch_d;
      mismatchCount_q <= mismatchCount_d;
    end
  end

  assign out_valid      = validChain[LAT];
  assign y              = dataChain[LAT];
  assign mismatch       = CHECK_EN ? mismatch_q : 1'b0;
  assign mismatch_count = CHECK_EN ? mismatchCount_q : '0;

endmodule

// File: tb/tb_cosim_logic_proxy.sv
// Bench for cosim_logic_proxy: directed and random steps checked every cycle
// against a transaction-queue reference model.
module tb_cosim_logic_proxy;

  localparam int WIDTH = 8;
  localparam int LAT   = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             mismatch;
  logic [15:0]      mismatch_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [WIDTH-1:0] res;
    bit               mis;
    int               age;
  } entry_t;

  entry_t pipeQ[$];
  bit     expMis   = 1'b0;
  int     expCount = 0;
  bit     stubOn   = 1'b0;

  cosim_logic_proxy #(
    .WIDTH    (WIDTH),
    .LAT      (LAT),
    .USE_MODEL(1),
    .CHECK    (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .op            (op),
    .a             (a),
    .b             (b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .y             (y),
    .mismatch      (mismatch),
    .mismatch_count(mismatch_count)
  );

  always #5 clk = ~clk;

  function automatic entry_t refEntry(logic [1:0] o, logic [WIDTH-1:0] x, logic [WIDTH-1:0] z);
    entry_t e;
    logic [WIDTH-1:0] nat;
    logic [WIDTH-1:0] mdl;
    case (o)
      2'd0:    nat = x & z;
      2'd1:    nat = x | z;
      2'd2:    nat = x ^ z;
      default: nat = ~(x & z);
    endcase
    mdl   = (stubOn && o == 2'd0) ? (x ^ z) : nat;
    e.res = mdl;
    e.mis = (mdl != nat);
    e.age = 0;
    return e;
  endfunction

  function automatic bit headVisible();
    if (pipeQ.size() == 0) return 1'b0;
    return (pipeQ[0].age == LAT - 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: drive at negedge, check outputs, then advance the model at posedge.
  task automatic applyStimulus(input logic rstV, input logic inV, input logic [1:0] opV,
                               input logic [WIDTH-1:0] aV, input logic [WIDTH-1:0] bV,
                               input logic outR);
    bit     vis;
    entry_t e;
    @(negedge clk);
    rst_n     = rstV;
    in_valid  = inV;
    op        = opV;
    a         = aV;
    b         = bV;
    out_ready = outR;
    #1;
    vis = headVisible();
    checkOutput("in_ready", 64'(in_ready), 64'(rstV && !(vis && !outR)));
    checkOutput("out_valid", 64'(out_valid), 64'(vis));
    if (vis) checkOutput("y", 64'(y), 64'(pipeQ[0].res));
    checkOutput("mismatch", 64'(mismatch), 64'(expMis));
    checkOutput("mismatch_count", 64'(mismatch_count), 64'(expCount));
    @(posedge clk);
    if (!rstV) begin
      pipeQ.delete();
      expMis   = 1'b0;
      expCount = 0;
    end else if (!(vis && !outR)) begin
      if (vis) begin
        e = pipeQ.pop_front();
        if (e.mis) begin
          expMis = 1'b1;
          if (expCount < 65535) expCount++;
        end
      end
      foreach (pipeQ[i]) pipeQ[i].age++;
      if (inV) pipeQ.push_back(refEntry(opV, aV, bV));
    end
  endtask

  task automatic idleCycles(input int n, input logic outR);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 2'd0, '0, '0, outR);
  endtask

  task automatic randomCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                    WIDTH'($urandom), WIDTH'($urandom), $urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 2'd0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state, then a single AND transfer.
    applyStimulus(1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'hF0, 8'h3C, 1'b1);
    idleCycles(3, 1'b1);

    // Four back-to-back ops.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1, 2'(k), 8'hAA, 8'h0F, 1'b1);
    idleCycles(3, 1'b1);

    // Consumer stall while transfers are queued; third op waits for in_ready.
    applyStimulus(1'b1, 1'b1, 2'd1, 8'h12, 8'h40, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd2, 8'h66, 8'h0F, 1'b0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1, 2'd3, 8'hC3, 8'h5A, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd3, 8'hC3, 8'h5A, 1'b1);
    idleCycles(4, 1'b1);

    randomCycles(150);
    idleCycles(4, 1'b1);

    // Faulty model: AND requests disagree with the native result.
    stubOn = 1'b1;
    cosim_logic_pkg::stubXorOnAnd = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h5A, 8'h3C, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h81, 8'hFF, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'd1, 8'h0F, 8'hF0, 1'b1);
    idleCycles(3, 1'b1);

    // Counter preset close to its ceiling.
    #2;
    force dut.mismatchCount_q = 16'hFFFD;
    #1;
    release dut.mismatchCount_q;
    expCount = 16'hFFFD;
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1, 2'd0, 8'h5A + 8'(k), 8'h33, 1'b1);
    idleCycles(3, 1'b1);

    // Reset with transfers in flight.
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h11, 8'h22, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'd2, 8'h33, 8'h44, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'h55, 8'h66, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd1, 8'h0C, 8'h30, 1'b1);
    idleCycles(4, 1'b1);

    randomCycles(100);
    for (int k = 0; k < 20 && pipeQ.size() != 0; k++) idleCycles(1, 1'b1);
    checkOutput("drained", 64'(pipeQ.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cosim_logic_proxy.md
COSIM_LOGIC_PROXY -- requirements
Module: cosim_logic_proxy

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result bit width (1..64).
REQ-002 The block SHALL have parameter LAT, default 2, accept-to-output pipeline depth in cycles (1..8).
REQ-003 The block SHALL have parameter USE_MODEL, default 1: 1 = result from system function $cxxrtl_logic_op; 0 = native RTL result only.
REQ-004 The block SHALL have parameter CHECK, default 1: 1 = compare model result against native result.
REQ-005 The block SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1, operand transfer request.
REQ-008 The block SHALL have port in_ready, output, 1, block can accept an operand.
REQ-009 The block SHALL have port op, input, 2, operation: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-010 The block SHALL have ports a and b, input, WIDTH, operands.
REQ-011 The block SHALL have port out_valid, output, 1, result available.
REQ-012 The block SHALL have port out_ready, input, 1, consumer accepts result.
REQ-013 The block SHALL have port y, output, WIDTH, result.
REQ-014 The block SHALL have port mismatch, output, 1, sticky model-vs-native disagreement flag.
REQ-015 The block SHALL have port mismatch_count, output, 16, number of mismatching results.

Function
REQ-016 The block SHALL accept a transfer on a rising edge with in_valid=1 and in_ready=1.
REQ-017 The block SHALL evaluate the model once per accepted transfer, in the accept cycle, with arguments (op, a, b); it SHALL NOT call the model on idle or stalled cycles.
REQ-018 The native result SHALL be the bitwise operation selected by op over all WIDTH bits; the model result SHALL be truncated or zero-extended to WIDTH.
REQ-019 With no stall, out_valid SHALL rise exactly LAT cycles after the accept edge, carrying that transfer's result and mismatch status.
REQ-020 Stall SHALL equal out_valid AND NOT out_ready; while stalled, all stages SHALL hold and y SHALL remain stable.
REQ-021 in_ready SHALL equal NOT stall, combinationally, so back-to-back accepts sustain one result per cycle.
REQ-022 A result SHALL leave on an edge with out_valid=1 and out_ready=1; a simultaneous accept on that edge SHALL be legal and lose no data.
REQ-023 Results SHALL emerge in accept order, with none dropped or duplicated.
REQ-024 With CHECK=1 and USE_MODEL=1, a result SHALL mismatch when the model value differs from the native value or contains X/Z.
REQ-025 A mismatching result SHALL set mismatch and increment mismatch_count in the cycle it leaves the block (out_valid AND out_ready).
REQ-026 mismatch_count SHALL saturate at 16'hFFFF.
REQ-027 With CHECK=0 or USE_MODEL=0, mismatch and mismatch_count SHALL be constant 0.
REQ-028 With USE_MODEL=1 and a mismatch, y SHALL present the model value with X/Z bits forced to 0.

Reset
REQ-029 While rst_n=0 at a rising edge: all stage-valid bits, out_valid, y, mismatch and mismatch_count SHALL clear to 0 on that edge, and in_ready SHALL be 0.
REQ-030 A reset asserted mid-operation SHALL discard in-flight transfers without output; the first accept after release SHALL behave per REQ-019.

Structure
REQ-031 Package cosim_logic_pkg SHALL hold the op encoding typedef (2-bit enum), the native-evaluation function, and the counter width constant (16).
REQ-032 One pipeline-stage sub-module, cosim_logic_stage (valid, data, mismatch bit, hold enable), SHALL be instantiated LAT times.
REQ-033 With USE_MODEL=0 the block SHALL be synthesizable; system-function calls SHALL be confined to a generate branch.

Verification
REQ-034 WIDTH=8, LAT=2: accept op=00, a=8'hF0, b=8'h3C; out_ready=1 -> out_valid 2 cycles later with y=8'h30, mismatch=0.
REQ-035 Four back-to-back accepts (ops 00..11, a=8'hAA, b=8'h0F), out_ready=1 -> in_ready stays 1; results 8'h0A, 8'hAF, 8'hA5, 8'hF5 on consecutive cycles.
REQ-036 Hold out_ready=0 for 5 cycles with 3 transfers in flight -> in_ready=0 while out_valid=1; y stable; all 3 results in order after release.
REQ-037 Model stub returns a XOR b for op=00 -> mismatch=1, mismatch_count increments by 1 per result; count preset near saturation holds at 16'hFFFF.
REQ-038 Assert rst_n=0 for one cycle with 2 transfers in flight -> no out_valid for those transfers; count and mismatch 0; the next accept appears after LAT cycles.
